// File: rtl/manchester_tx_sequencer.sv
// Frame sequencer feeding an NRZ-to-Manchester encoder: preamble + payload (+ optional
// even parity when MANCHESTER_TX_PARITY_EN is defined), MSB-first, with half-bit timing.
module manchester_tx_sequencer #(
  parameter int          DATA_WIDTH        = 8,
  parameter int          PREAMBLE_LEN      = 8,
  parameter logic [31:0] PREAMBLE_PAT      = 32'hAA,
  parameter int          CLKS_PER_HALF_BIT = 1,
  parameter int          GAP_BITS          = 2
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] tx_data,
  input  logic                  tx_valid,
  output logic                  tx_ready,
  output logic                  nrz_out,
  output logic                  enc_phase,
  output logic                  line_active,
  output logic                  busy,
  output logic                  done
);

`ifdef MANCHESTER_TX_PARITY_EN
  localparam int PAR_BITS = 1;
`else
  localparam int PAR_BITS = 0;
`endif

  localparam int FRAME_W = PREAMBLE_LEN + DATA_WIDTH + PAR_BITS;
  localparam int CNT_MAX = (PREAMBLE_LEN > DATA_WIDTH + 1) ? PREAMBLE_LEN : DATA_WIDTH + 1;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int HALF_W  = (CLKS_PER_HALF_BIT > 1) ? $clog2(CLKS_PER_HALF_BIT) : 1;
  localparam int GAP_CYC = GAP_BITS * 2 * CLKS_PER_HALF_BIT;
  localparam int GAP_W   = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;

  localparam logic [HALF_W-1:0] HALF_LAST = HALF_W'(CLKS_PER_HALF_BIT - 1);
  localparam logic [CNT_W-1:0]  PRE_LAST  = CNT_W'(PREAMBLE_LEN - 1);
  localparam logic [CNT_W-1:0]  DATA_LAST = CNT_W'(DATA_WIDTH - 1);
  localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(GAP_CYC - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRE,
    S_DATA,
`ifdef MANCHESTER_TX_PARITY_EN
    S_PAR,
`endif
    S_GAP
  } state_t;

  localparam state_t AFTER_FRAME = (GAP_CYC == 0) ? S_IDLE : S_GAP;

  state_t               state_q, state_n;
  logic [HALF_W-1:0]    half_q, half_n;
  logic                 phase_q, phase_n;
  logic [CNT_W-1:0]     bit_q, bit_n;
  logic [GAP_W-1:0]     gap_q, gap_n;
  logic [FRAME_W-1:0]   sh_q, sh_n;
  logic                 ready_q, ready_n;
  logic                 active_q, active_n;
  logic                 busy_q, busy_n;
  logic                 done_q, done_n;
  logic                 bit_end;
  logic                 last_bit_n;
  logic [FRAME_W-1:0]   frame_word;

  // The whole frame is loaded at accept and shifted out; zeros shift in, so the
  // register's MSB is already 0 once the frame has drained (GAP and IDLE).
`ifdef MANCHESTER_TX_PARITY_EN
  assign frame_word = {PREAMBLE_PAT[PREAMBLE_LEN-1:0], tx_data, ^tx_data};
`else
  assign frame_word = {PREAMBLE_PAT[PREAMBLE_LEN-1:0], tx_data};
`endif

  always_comb begin
    // NOTE: every next-value gets a default first so no path leaves a signal unassigned (no latches).
    state_n = state_q;
    half_n  = half_q;
    phase_n = phase_q;
    bit_n   = bit_q;
    gap_n   = gap_q;
    sh_n    = sh_q;
    bit_end = 1'b0;

    if (active_q) begin
      if (half_q == HALF_LAST) begin
        half_n  = '0;
        phase_n = ~phase_q;
        bit_end = phase_q;
      end else begin
        half_n = half_q + 1'b1;
      end
    end

    if (bit_end) sh_n = {sh_q[FRAME_W-2:0], 1'b0};

    case (state_q)
      S_IDLE: begin
        if (tx_valid && ready_q) begin
          state_n = S_PRE;
          sh_n    = frame_word;
          half_n  = '0;
          phase_n = 1'b0;
          bit_n   = '0;
        end
      end
      S_PRE: begin
        if (bit_end) begin
          if (bit_q == PRE_LAST) begin
            state_n = S_DATA;
            bit_n   = '0;
          end else begin
            bit_n = bit_q + 1'b1;
          end
        end
      end
      S_DATA: begin
        if (bit_end) begin
          if (bit_q == DATA_LAST) begin
`ifdef MANCHESTER_TX_PARITY_EN
            state_n = S_PAR;
`else
            state_n = AFTER_FRAME;
`endif
            bit_n = '0;
            gap_n = '0;
          end else begin
            bit_n = bit_q + 1'b1;
          end
        end
      end
`ifdef MANCHESTER_TX_PARITY_EN
      S_PAR: begin
        if (bit_end) begin
          state_n = AFTER_FRAME;
          gap_n   = '0;
        end
      end
`endif
      S_GAP: begin
        if (gap_q == GAP_LAST) state_n = S_IDLE;
        else                   gap_n   = gap_q + 1'b1;
      end
      default: state_n = S_IDLE;
    endcase

    // Status outputs are registered from the next-state view so they line up with the bit.
`ifdef MANCHESTER_TX_PARITY_EN
    active_n   = (state_n == S_PRE) || (state_n == S_DATA) || (state_n == S_PAR);
    last_bit_n = (state_n == S_PAR);
`else
    active_n   = (state_n == S_PRE) || (state_n == S_DATA);
    last_bit_n = (state_n == S_DATA) && (bit_n == DATA_LAST);
`endif
    ready_n = (state_n == S_IDLE);
    busy_n  = (state_n != S_IDLE);
    done_n  = last_bit_n && phase_n && (half_n == HALF_LAST);
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      half_q   <= '0;
      phase_q  <= 1'b0;
      bit_q    <= '0;
      gap_q    <= '0;
      sh_q     <= '0;
      ready_q  <= 1'b1;
      active_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_n;
      half_q   <= half_n;
      phase_q  <= phase_n;
      bit_q    <= bit_n;
      gap_q    <= gap_n;
      sh_q     <= sh_n;
      ready_q  <= ready_n;
      active_q <= active_n;
      busy_q   <= busy_n;
      done_q   <= done_n;
    end
  end

  assign tx_ready    = ready_q;
  assign nrz_out     = sh_q[FRAME_W-1];
  assign enc_phase   = phase_q;
  assign line_active = active_q;
  assign busy        = busy_q;
  assign done        = done_q;

endmodule
